// File: rtl/temp_disp_pkg.sv
// Shared types and constants for the temperature display path.
// TEMP_FAHRENHEIT_EN widens the magnitude to 9 bits for the Fahrenheit conversion.
package temp_disp_pkg;

    localparam int unsigned TEMP_W = 8;
    localparam int unsigned BCD_W  = 12;
`ifdef TEMP_FAHRENHEIT_EN
    localparam int unsigned MAG_W  = 9;
`else
    localparam int unsigned MAG_W  = 8;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // 0-9 are decimal digits, the two codes above are the non-numeric glyphs
    typedef logic [3:0] digit_code_t;
    localparam digit_code_t CODE_BLANK = 4'd10;
    localparam digit_code_t CODE_MINUS = 4'd11;

    typedef struct packed {
        digit_code_t sign;
        digit_code_t hund;
        digit_code_t tens;
        digit_code_t ones;
    } digits_t;

    localparam digits_t DIGITS_RESET = '{
        sign: CODE_BLANK, hund: CODE_BLANK, tens: CODE_BLANK, ones: 4'd0
    };

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_MINUS = 7'h3F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    function automatic logic [6:0] glyph(input digit_code_t code);
        logic [6:0] g;
        case (code)
            4'd0:       g = GLYPH_0;
            4'd1:       g = GLYPH_1;
            4'd2:       g = GLYPH_2;
            4'd3:       g = GLYPH_3;
            4'd4:       g = GLYPH_4;
            4'd5:       g = GLYPH_5;
            4'd6:       g = GLYPH_6;
            4'd7:       g = GLYPH_7;
            4'd8:       g = GLYPH_8;
            4'd9:       g = GLYPH_9;
            CODE_MINUS: g = GLYPH_MINUS;
            default:    g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per cycle, MAG_W steps per conversion.
// Width follows MAG_W, which TEMP_FAHRENHEIT_EN selects in the package.
module bin2bcd_seq
    import temp_disp_pkg::*;
(
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               start,
    input  logic [MAG_W-1:0]   bin,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    localparam int unsigned SR_W  = BCD_W + MAG_W;
    localparam int unsigned CNT_W = $clog2(MAG_W);

    logic [SR_W-1:0]  sr_q;
    logic [SR_W-1:0]  sr_adj_c;
    logic [CNT_W-1:0] iter_q;
    logic             busy_q;

    // Add 3 to every BCD nibble that is 5 or more ahead of the shift
    always_comb begin
        sr_adj_c = sr_q;
        for (int i = 0; i < int'(BCD_W / 4); i++) begin
            if (sr_q[MAG_W + 4*i +: 4] >= 4'd5) begin
                sr_adj_c[MAG_W + 4*i +: 4] = sr_q[MAG_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then shift once per cycle until all MAG_W bits are consumed
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sr_q   <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr_q   <= {BCD_W'(0), bin};
                iter_q <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                sr_q   <= {sr_adj_c[SR_W-2:0], 1'b0};
                iter_q <= iter_q + CNT_W'(1);
                if (iter_q == CNT_W'(MAG_W - 1)) begin
                    busy_q <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    assign bcd = sr_q[SR_W-1:MAG_W];

endmodule

// File: rtl/temp_display_mux.sv
// Signed temperature byte -> BCD -> four-digit multiplexed common-anode display.
// Define TEMP_FAHRENHEIT_EN to show degrees Fahrenheit instead of Celsius.
module temp_display_mux
    import temp_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter int unsigned STABLE_CYCLES = 2
)(
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic [7:0]  temp_data,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        upd
);

    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);

    logic [TEMP_W-1:0] cand_q;
    logic [STB_W-1:0]  run_q;
    logic [TEMP_W-1:0] last_val_q;
    logic              accept_c;

    state_t            state_q;
    state_t            state_n;
    logic              start_c;
    logic              commit_c;

    logic [MAG_W-1:0]  mag_c;
    logic              neg_c;
    logic              neg_q;
    logic              cvt_done;
    logic [BCD_W-1:0]  cvt_bcd;

    digits_t           digits_q;
    digits_t           digits_c;

    logic [REF_W-1:0]  ref_cnt_q;
    logic [1:0]        digit_sel_q;
    digit_code_t       slot_code_c;

    assign dp = 1'b1;

    // Track how long the current sample has been unchanged (saturating)
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            cand_q <= '0;
            run_q  <= '0;
        end else if (temp_data != cand_q) begin
            cand_q <= temp_data;
            run_q  <= STB_W'(1);
        end else if (run_q < STB_W'(STABLE_CYCLES)) begin
            run_q  <= run_q + STB_W'(1);
        end
    end

    assign accept_c = (run_q >= STB_W'(STABLE_CYCLES)) && (cand_q != last_val_q);

`ifdef TEMP_FAHRENHEIT_EN
    // F = C*9/5 + 32 computed as (|C*9+160| + 2) / 5; 127*9+160 needs 12 bits
    logic signed [11:0] f_x_c;
    logic        [11:0] f_abs_c;

    always_comb begin
        f_x_c   = $signed({{4{cand_q[7]}}, cand_q}) * 12'sd9 + 12'sd160;
        f_abs_c = f_x_c[11] ? 12'(-f_x_c) : 12'(f_x_c);
        mag_c   = MAG_W'((f_abs_c + 12'd2) / 12'd5);
        neg_c   = f_x_c[11] && (mag_c != '0);
    end
`else
    // Celsius magnitude; -128 wraps to 8'h80, which reads as 128
    always_comb begin
        mag_c = cand_q[7] ? MAG_W'(-cand_q) : MAG_W'(cand_q);
        neg_c = cand_q[7];
    end
`endif

    // FSM state register
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_n = CONV;
            CONV:    if (cvt_done) state_n = COMMIT;
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM outputs: kick the converter on acceptance, publish digits on commit
    always_comb begin
        start_c  = 1'b0;
        commit_c = 1'b0;
        case (state_q)
            IDLE:    start_c  = accept_c;
            COMMIT:  commit_c = 1'b1;
            default: ;
        endcase
    end

    bin2bcd_seq u_bin2bcd (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .start      (start_c),
        .bin        (mag_c),
        .done       (cvt_done),
        .bcd        (cvt_bcd)
    );

    // Leading-zero suppression and sign placement
    always_comb begin
        digits_c      = DIGITS_RESET;
        digits_c.ones = cvt_bcd[3:0];
        digits_c.tens = ((cvt_bcd[11:8] == 4'd0) && (cvt_bcd[7:4] == 4'd0)) ? CODE_BLANK
                                                                             : cvt_bcd[7:4];
        digits_c.hund = (cvt_bcd[11:8] == 4'd0) ? CODE_BLANK : cvt_bcd[11:8];
        digits_c.sign = neg_q ? CODE_MINUS : CODE_BLANK;
    end

    // Accepted value, sign and displayed digits; upd marks each commit
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            last_val_q <= '0;
            neg_q      <= 1'b0;
            digits_q   <= DIGITS_RESET;
            upd        <= 1'b0;
        end else begin
            upd <= commit_c;
            if (start_c) begin
                last_val_q <= cand_q;
                neg_q      <= neg_c;
            end
            if (commit_c) begin
                digits_q <= digits_c;
            end
        end
    end

    // Digit code for the slot about to be driven
    always_comb begin
        slot_code_c = digits_q.ones;
        case (digit_sel_q)
            2'd1:    slot_code_c = digits_q.tens;
            2'd2:    slot_code_c = digits_q.hund;
            2'd3:    slot_code_c = digits_q.sign;
            default: slot_code_c = digits_q.ones;
        endcase
    end

    // Refresh scan: digit_sel names the next slot, entered on each counter wrap
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            ref_cnt_q   <= '0;
            digit_sel_q <= 2'd0;
            an          <= 4'hF;
            seg         <= GLYPH_BLANK;
        end else if (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt_q   <= '0;
            digit_sel_q <= digit_sel_q + 2'd1;
            an          <= ~(4'b0001 << digit_sel_q);
            seg         <= glyph(slot_code_c);
        end else begin
            ref_cnt_q   <= ref_cnt_q + REF_W'(1);
        end
    end

endmodule
